// File: rtl/id_exe_cond_reg_if.sv
// Bundle of decode-stage inputs and registered execute-stage outputs
// for the ID->EXE conditional pipeline register.
interface id_exe_cond_reg_if #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
);
    logic               freeze;
    logic               flush;
    logic               cond_pass;
    logic               id_valid;
    logic [DATA_W-1:0]  id_pc;
    logic [DATA_W-1:0]  id_val_rn;
    logic [DATA_W-1:0]  id_val_rm;
    logic [3:0]         id_exe_cmd;
    logic               id_mem_r_en;
    logic               id_mem_w_en;
    logic               id_wb_en;
    logic               id_s;
    logic               id_b;
    logic               id_imm;
    logic [11:0]        id_shift_op;
    logic [23:0]        id_simm24;
    logic [RADDR_W-1:0] id_dest;
    logic [RADDR_W-1:0] id_src1;
    logic [RADDR_W-1:0] id_src2;
    logic [3:0]         id_status;

    logic [DATA_W-1:0]  exe_pc;
    logic [DATA_W-1:0]  exe_val_rn;
    logic [DATA_W-1:0]  exe_val_rm;
    logic [3:0]         exe_exe_cmd;
    logic               exe_mem_r_en;
    logic               exe_mem_w_en;
    logic               exe_wb_en;
    logic               exe_s;
    logic               exe_b;
    logic               exe_imm;
    logic [11:0]        exe_shift_op;
    logic [23:0]        exe_simm24;
    logic [RADDR_W-1:0] exe_dest;
    logic [RADDR_W-1:0] exe_src1;
    logic [RADDR_W-1:0] exe_src2;
    logic [3:0]         exe_status;
    logic               exe_valid;
    logic [CNT_W-1:0]   squash_cnt;

    modport master (
        output freeze, flush, cond_pass, id_valid, id_pc, id_val_rn, id_val_rm,
               id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_s, id_b, id_imm,
               id_shift_op, id_simm24, id_dest, id_src1, id_src2, id_status,
        input  exe_pc, exe_val_rn, exe_val_rm, exe_exe_cmd, exe_mem_r_en,
               exe_mem_w_en, exe_wb_en, exe_s, exe_b, exe_imm, exe_shift_op,
               exe_simm24, exe_dest, exe_src1, exe_src2, exe_status, exe_valid,
               squash_cnt
    );

    modport slave (
        input  freeze, flush, cond_pass, id_valid, id_pc, id_val_rn, id_val_rm,
               id_exe_cmd, id_mem_r_en, id_mem_w_en, id_wb_en, id_s, id_b, id_imm,
               id_shift_op, id_simm24, id_dest, id_src1, id_src2, id_status,
        output exe_pc, exe_val_rn, exe_val_rm, exe_exe_cmd, exe_mem_r_en,
               exe_mem_w_en, exe_wb_en, exe_s, exe_b, exe_imm, exe_shift_op,
               exe_simm24, exe_dest, exe_src1, exe_src2, exe_status, exe_valid,
               squash_cnt
    );
endinterface

// File: rtl/id_exe_cond_reg.sv
// ID->EXE pipeline register: squashes side effects of condition-failed
// instructions, supports stall/flush, and counts squashes (saturating).
module id_exe_cond_reg #(
    parameter int DATA_W  = 32,
    parameter int RADDR_W = 4,
    parameter int CNT_W   = 16
) (
    input logic              clk,
    input logic              rst,
    id_exe_cond_reg_if.slave bus
);
    localparam logic [DATA_W-1:0]  DataZero = '0;
    localparam logic [RADDR_W-1:0] RegZero  = '0;
    localparam logic [CNT_W-1:0]   CntOne   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]   CntMax   = '1;

    logic live;
    logic squash;

    assign live   = bus.id_valid & bus.cond_pass;
    assign squash = bus.id_valid & ~bus.cond_pass;

    // Data fields are always captured on a load; only the side-effect bits
    // and the valid flag depend on whether the instruction is live.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            bus.exe_pc       <= DataZero;
            bus.exe_val_rn   <= DataZero;
            bus.exe_val_rm   <= DataZero;
            bus.exe_exe_cmd  <= 4'd0;
            bus.exe_mem_r_en <= 1'b0;
            bus.exe_mem_w_en <= 1'b0;
            bus.exe_wb_en    <= 1'b0;
            bus.exe_s        <= 1'b0;
            bus.exe_b        <= 1'b0;
            bus.exe_imm      <= 1'b0;
            bus.exe_shift_op <= 12'd0;
            bus.exe_simm24   <= 24'd0;
            bus.exe_dest     <= RegZero;
            bus.exe_src1     <= RegZero;
            bus.exe_src2     <= RegZero;
            bus.exe_status   <= 4'd0;
            bus.exe_valid    <= 1'b0;
        end else if (!bus.freeze) begin
            bus.exe_pc       <= bus.id_pc;
            bus.exe_val_rn   <= bus.id_val_rn;
            bus.exe_val_rm   <= bus.id_val_rm;
            bus.exe_exe_cmd  <= bus.id_exe_cmd;
            bus.exe_mem_r_en <= bus.id_mem_r_en & live;
            bus.exe_mem_w_en <= bus.id_mem_w_en & live;
            bus.exe_wb_en    <= bus.id_wb_en & live;
            bus.exe_s        <= bus.id_s & live;
            bus.exe_b        <= bus.id_b & live;
            bus.exe_imm      <= bus.id_imm;
            bus.exe_shift_op <= bus.id_shift_op;
            bus.exe_simm24   <= bus.id_simm24;
            bus.exe_dest     <= bus.id_dest;
            bus.exe_src1     <= bus.id_src1;
            bus.exe_src2     <= bus.id_src2;
            bus.exe_status   <= bus.id_status;
            bus.exe_valid    <= live;
        end
    end

    // Only reset clears the counter; flush and freeze leave it untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.squash_cnt <= '0;
        end else if (!bus.flush && !bus.freeze && squash && bus.squash_cnt != CntMax) begin
            bus.squash_cnt <= bus.squash_cnt + CntOne;
        end
    end
endmodule

// File: tb/tb_id_exe_cond_reg.sv
// Scoreboard bench for id_exe_cond_reg: a behavioural model queues the expected
// EXE-side state for every cycle and a monitor compares it after each edge.
module tb_id_exe_cond_reg;
    localparam int DATA_W  = 32;
    localparam int RADDR_W = 4;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct packed {
        logic        rst;
        logic        flush;
        logic        freeze;
        logic        cond_pass;
        logic        id_valid;
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        s;
        logic        b;
        logic        imm;
        logic [11:0] shift_op;
        logic [23:0] simm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  status;
    } stim_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [3:0]  exe_cmd;
        logic        mem_r_en;
        logic        mem_w_en;
        logic        wb_en;
        logic        s;
        logic        b;
        logic        imm;
        logic [11:0] shift_op;
        logic [23:0] simm24;
        logic [3:0]  dest;
        logic [3:0]  src1;
        logic [3:0]  src2;
        logic [3:0]  status;
        logic        valid;
        logic [3:0]  cnt;
    } out_t;

    logic clk = 1'b0;
    logic rst;

    id_exe_cond_reg_if #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) bus ();

    id_exe_cond_reg #(.DATA_W(DATA_W), .RADDR_W(RADDR_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    out_t  exp_q[$];
    string tag_q[$];
    out_t  mdl;
    int    mdl_cnt;
    int    n_checks;
    int    n_fails;

    function automatic stim_t rand_stim();
        stim_t st;
        st.rst       = 1'b0;
        st.flush     = 1'b0;
        st.freeze    = 1'b0;
        st.id_valid  = 1'b1;
        st.cond_pass = 1'($urandom_range(0, 1));
        st.pc        = $urandom;
        st.val_rn    = $urandom;
        st.val_rm    = $urandom;
        st.exe_cmd   = 4'($urandom);
        st.mem_r_en  = 1'($urandom_range(0, 1));
        st.mem_w_en  = 1'($urandom_range(0, 1));
        st.wb_en     = 1'($urandom_range(0, 1));
        st.s         = 1'($urandom_range(0, 1));
        st.b         = 1'($urandom_range(0, 1));
        st.imm       = 1'($urandom_range(0, 1));
        st.shift_op  = 12'($urandom);
        st.simm24    = 24'($urandom);
        st.dest      = 4'($urandom);
        st.src1      = 4'($urandom);
        st.src2      = 4'($urandom);
        st.status    = 4'($urandom);
        return st;
    endfunction

    // Drive one cycle of inputs and queue what EXE must hold after the edge.
    task automatic applyStimulus(input stim_t st, input string tag);
        bit keep;
        @(negedge clk);
        rst             = st.rst;
        bus.flush       = st.flush;
        bus.freeze      = st.freeze;
        bus.cond_pass   = st.cond_pass;
        bus.id_valid    = st.id_valid;
        bus.id_pc       = st.pc;
        bus.id_val_rn   = st.val_rn;
        bus.id_val_rm   = st.val_rm;
        bus.id_exe_cmd  = st.exe_cmd;
        bus.id_mem_r_en = st.mem_r_en;
        bus.id_mem_w_en = st.mem_w_en;
        bus.id_wb_en    = st.wb_en;
        bus.id_s        = st.s;
        bus.id_b        = st.b;
        bus.id_imm      = st.imm;
        bus.id_shift_op = st.shift_op;
        bus.id_simm24   = st.simm24;
        bus.id_dest     = st.dest;
        bus.id_src1     = st.src1;
        bus.id_src2     = st.src2;
        bus.id_status   = st.status;

        if (st.rst) begin
            mdl     = '0;
            mdl_cnt = 0;
        end else if (st.flush) begin
            mdl = '0;
        end else if (!st.freeze) begin
            keep         = st.id_valid && st.cond_pass;
            mdl.pc       = st.pc;
            mdl.val_rn   = st.val_rn;
            mdl.val_rm   = st.val_rm;
            mdl.exe_cmd  = st.exe_cmd;
            mdl.imm      = st.imm;
            mdl.shift_op = st.shift_op;
            mdl.simm24   = st.simm24;
            mdl.dest     = st.dest;
            mdl.src1     = st.src1;
            mdl.src2     = st.src2;
            mdl.status   = st.status;
            mdl.mem_r_en = keep ? st.mem_r_en : 1'b0;
            mdl.mem_w_en = keep ? st.mem_w_en : 1'b0;
            mdl.wb_en    = keep ? st.wb_en : 1'b0;
            mdl.s        = keep ? st.s : 1'b0;
            mdl.b        = keep ? st.b : 1'b0;
            mdl.valid    = keep;
            if (st.id_valid && !st.cond_pass && mdl_cnt < CNT_MAX) begin
                mdl_cnt = mdl_cnt + 1;
            end
        end
        mdl.cnt = 4'(mdl_cnt);
        exp_q.push_back(mdl);
        tag_q.push_back(tag);
    endtask

    task automatic checkOutput();
        out_t  got;
        out_t  exp;
        string tag;
        exp = exp_q.pop_front();
        tag = tag_q.pop_front();
        got.pc       = bus.exe_pc;
        got.val_rn   = bus.exe_val_rn;
        got.val_rm   = bus.exe_val_rm;
        got.exe_cmd  = bus.exe_exe_cmd;
        got.mem_r_en = bus.exe_mem_r_en;
        got.mem_w_en = bus.exe_mem_w_en;
        got.wb_en    = bus.exe_wb_en;
        got.s        = bus.exe_s;
        got.b        = bus.exe_b;
        got.imm      = bus.exe_imm;
        got.shift_op = bus.exe_shift_op;
        got.simm24   = bus.exe_simm24;
        got.dest     = bus.exe_dest;
        got.src1     = bus.exe_src1;
        got.src2     = bus.exe_src2;
        got.status   = bus.exe_status;
        got.valid    = bus.exe_valid;
        got.cnt      = bus.squash_cnt;
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %h required %h (valid %b/%b cnt %0d/%0d)",
                     tag, got, exp, got.valid, exp.valid, got.cnt, exp.cnt);
        end
    endtask

    // The register presents a fresh state every edge, so the monitor samples
    // once per cycle whenever an expectation is pending.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) checkOutput();
        end
    end

    initial begin
        stim_t st;
        int    waited;
        n_checks = 0;
        n_fails  = 0;
        mdl      = '0;
        mdl_cnt  = 0;
        rst      = 1'b1;
        bus.flush = 1'b0;  bus.freeze = 1'b0;  bus.cond_pass = 1'b0;  bus.id_valid = 1'b0;
        bus.id_pc = '0;  bus.id_val_rn = '0;  bus.id_val_rm = '0;  bus.id_exe_cmd = '0;
        bus.id_mem_r_en = 1'b0;  bus.id_mem_w_en = 1'b0;  bus.id_wb_en = 1'b0;
        bus.id_s = 1'b0;  bus.id_b = 1'b0;  bus.id_imm = 1'b0;  bus.id_shift_op = '0;
        bus.id_simm24 = '0;  bus.id_dest = '0;  bus.id_src1 = '0;  bus.id_src2 = '0;
        bus.id_status = '0;

        st = rand_stim();
        st.rst = 1'b1;
        applyStimulus(st, "reset");

        st = rand_stim();
        st.cond_pass = 1'b1;  st.wb_en = 1'b1;  st.dest = 4'd5;  st.val_rn = 32'h1234;
        applyStimulus(st, "pass");

        st = rand_stim();
        st.cond_pass = 1'b0;  st.mem_w_en = 1'b1;  st.b = 1'b1;
        applyStimulus(st, "squash");

        st = rand_stim();
        st.id_valid = 1'b0;  st.cond_pass = 1'b1;  st.wb_en = 1'b1;
        applyStimulus(st, "bubble_in");

        st = rand_stim();
        st.cond_pass = 1'b1;
        applyStimulus(st, "pre_freeze");
        for (int i = 0; i < 3; i++) begin
            st = rand_stim();
            st.freeze = 1'b1;  st.cond_pass = 1'b0;
            applyStimulus(st, "freeze_hold");
        end
        st = rand_stim();
        st.cond_pass = 1'b1;
        applyStimulus(st, "freeze_release");

        st = rand_stim();
        st.flush = 1'b1;  st.freeze = 1'b1;  st.cond_pass = 1'b0;
        applyStimulus(st, "flush_over_freeze");

        st = rand_stim();
        st.cond_pass = 1'b1;
        applyStimulus(st, "post_flush");

        for (int i = 0; i < 300; i++) begin
            st = rand_stim();
            st.rst      = ($urandom_range(0, 49) == 0);
            st.flush    = ($urandom_range(0, 9) == 0);
            st.freeze   = ($urandom_range(0, 4) == 0);
            st.id_valid = ($urandom_range(0, 3) != 0);
            applyStimulus(st, "random");
        end

        st = rand_stim();
        st.rst = 1'b1;
        applyStimulus(st, "pre_sat_reset");
        for (int i = 0; i < 20; i++) begin
            st = rand_stim();
            st.cond_pass = 1'b0;
            applyStimulus(st, "saturate");
        end
        st = rand_stim();
        st.cond_pass = 1'b1;
        applyStimulus(st, "sat_pass");

        st = rand_stim();
        st.rst = 1'b1;  st.freeze = 1'b1;  st.flush = 1'b1;
        applyStimulus(st, "reset_mid_stall");

        st = rand_stim();
        st.cond_pass = 1'b0;
        applyStimulus(st, "count_after_reset");

        waited = 0;
        while (exp_q.size() > 0 && waited < 10) begin
            @(posedge clk);
            waited++;
        end
        #2;
        if (exp_q.size() > 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
